axil_reg_bank: RTL and testbench
================================

// Module: axil_reg_bank
// PURPOSE
//   Parametrised AXI4-Lite slave register bank; generalises the fixed 4x32-bit slave-register IP to NUM_REGS words of DATA_W bits.
//   Adds byte strobes, SLVERR on out-of-range addresses, per-register write pulses and optional TMR storage for fault tolerance.
//   Sits between the AXI interconnect and per-core control/status logic; regs_out drives the fabric directly.
// PARAMETERS
//   DATA_W     32  data bus width; must be 32 or 64
//   NUM_REGS   4   number of word registers; >=1
//   ADDR_W     4   AXI address width; 2^ADDR_W >= NUM_REGS*(DATA_W/8)
//   RESET_VAL  0   reset value of every register, DATA_W bits
// PORTS
//   ACLK           in   1                  clock; all logic on rising edge
//   ARESETN        in   1                  synchronous active-low reset
//   S_AXI_AWADDR   in   ADDR_W             write address
//   S_AXI_AWVALID  in   1                  write address valid
//   S_AXI_AWREADY  out  1                  write address ready
//   S_AXI_WDATA    in   DATA_W             write data
//   S_AXI_WSTRB    in   DATA_W/8           byte strobes
//   S_AXI_WVALID   in   1                  write data valid
//   S_AXI_WREADY   out  1                  write data ready
//   S_AXI_BRESP    out  2                  00 OKAY, 10 SLVERR
//   S_AXI_BVALID   out  1                  write response valid
//   S_AXI_BREADY   in   1                  write response ready
//   S_AXI_ARADDR   in   ADDR_W             read address
//   S_AXI_ARVALID  in   1                  read address valid
//   S_AXI_ARREADY  out  1                  read address ready
//   S_AXI_RDATA    out  DATA_W             read data
//   S_AXI_RRESP    out  2                  00 OKAY, 10 SLVERR
//   S_AXI_RVALID   out  1                  read data valid
//   S_AXI_RREADY   in   1                  read data ready
//   regs_out       out  NUM_REGS*DATA_W    register contents; reg k at [k*DATA_W +: DATA_W]
//   wr_pulse       out  NUM_REGS           one-cycle pulse per register on committed write
//   tmr_err        out  1                  one-cycle pulse on copy mismatch (0 when TMR compiled out)
// BEHAVIOUR
//   - Index = ADDR[ADDR_W-1:log2(DATA_W/8)]; low byte-offset bits ignored. Index >= NUM_REGS -> SLVERR, no write; read returns RDATA=0.
//   - Reset (ARESETN=0 at edge): regs=RESET_VAL, all READY/VALID=0, RESP=00, RDATA=0, wr_pulse=0, tmr_err=0. First cycle after reset: AWREADY=WREADY=ARREADY=1.
//   - Reset mid-transaction: pending AW/W/AR dropped; no B or R response issued.
//   - Write FSM states W_IDLE, W_COMMIT, W_RESP. In W_IDLE, AW and W are captured independently in any order or in the same cycle.
//     Each READY deasserts once its channel is latched.
//   - Both captured at edge N -> W_COMMIT; at edge N+1 register updated per WSTRB byte lanes, BVALID=1, wr_pulse[idx]=1 for one cycle, state W_RESP.
//   - W_RESP: BVALID and BRESP held until BREADY. On the B handshake edge -> W_IDLE with AWREADY=WREADY=1 next cycle. One outstanding write.
//   - Read FSM states R_IDLE, R_DATA. AR handshake at edge N captures contents; after edge N RVALID=1, RDATA and RRESP registered.
//     ARREADY=0 while RVALID; RDATA held stable until RREADY; -> R_IDLE.
//   - Same-edge AR handshake and write commit to the same register: read returns the old value.
//   - WSTRB=0 on a valid address: OKAY response, register unchanged, wr_pulse still fires.
// CONFIGURATION
//   AXIL_REG_BANK_TMR_EN defined: each register is stored as three copies tmr_copy[0..2]. regs_out and RDATA use the bitwise majority vote.
//     Any copy mismatch -> tmr_err=1 for one cycle; next edge all three copies are rewritten with the voted value.
//     A write commit to that register on the same edge takes priority over the rewrite.
//   Not defined: single copy per register; tmr_err tied to 0.
// TESTING
//   1) Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read back -> RDATA 0x1..0x4 in order, all BRESP/RRESP=00.
//   2) Write 0xAABBCCDD to 0x4, then 0x11223344 with WSTRB=4'b0101 -> read 0x4 returns 0xAA22CC44.
//   3) NUM_REGS=4: write 0xDEAD to 0x10 -> BRESP=10 and regs unchanged; read 0x10 -> RDATA=0, RRESP=10.
//   4) WVALID 3 cycles before AWVALID, BREADY low for 5 cycles -> BVALID held; AWREADY/WREADY stay 0 until the B handshake; wr_pulse[1] high exactly 1 cycle.
//   5) ARESETN low for one edge while BVALID=1 -> BVALID=0, regs=RESET_VAL, no B response issued afterwards.
//   6) TMR_EN: force tmr_copy[1] of reg 2 bit0 flipped -> RDATA for reg 2 unchanged, tmr_err one 1-cycle pulse, copy restored within 2 cycles.

Source files
------------

// File: rtl/axil_reg_bank.sv
// axil_reg_bank: parametrised AXI4-Lite register bank with byte strobes, SLVERR, write pulses.
// Optional triple-redundant storage when AXIL_REG_BANK_TMR_EN is defined.  Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module axil_reg_bank #(
  parameter int                DATA_W    = 32,
  parameter int                NUM_REGS  = 4,
  parameter int                ADDR_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                         ACLK,
  input  logic                         ARESETN,
  input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_W-1:0]            S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]          S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_W-1:0]            S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic [NUM_REGS-1:0]          wr_pulse,
  output logic                         tmr_err
);

  localparam int              STRB_W   = DATA_W / 8;
  localparam int              ADDR_LSB = $clog2(STRB_W);
  localparam int              IDX_W    = ADDR_W - ADDR_LSB;
  localparam logic [IDX_W:0]  NREGS    = (IDX_W + 1)'(NUM_REGS);

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}           rstate_t;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < STRB_W; b++)
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    return res;
  endfunction

  // Current (voted, when TMR is on) register contents.
  logic [DATA_W-1:0] cur [NUM_REGS];

  wire unused_addr_lsbs = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // ---------------- write channel ----------------
  wstate_t             wstate, wstate_nx;
  logic                aw_ready, w_ready, have_aw, have_w;
  logic                aw_hs, w_hs, have_aw_nx, have_w_nx, commit;
  logic [IDX_W-1:0]    aw_idx;
  logic                aw_ok;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                bvalid;
  logic [1:0]          bresp;
  logic [NUM_REGS-1:0] wr_sel;

  always_comb begin
    wstate_nx  = wstate;
    aw_hs      = (wstate == W_IDLE) && S_AXI_AWVALID && aw_ready;
    w_hs       = (wstate == W_IDLE) && S_AXI_WVALID && w_ready;
    have_aw_nx = have_aw | aw_hs;
    have_w_nx  = have_w | w_hs;
    commit     = (wstate == W_COMMIT);
    case (wstate)
      W_IDLE:   if (have_aw_nx && have_w_nx) wstate_nx = W_COMMIT;
      W_COMMIT: wstate_nx = W_RESP;
      W_RESP:   if (S_AXI_BREADY) wstate_nx = W_IDLE;
      default:  wstate_nx = W_IDLE;
    endcase
  end

  always_comb begin
    wr_sel = '0;
    for (int k = 0; k < NUM_REGS; k++)
      wr_sel[k] = aw_ok && (aw_idx == IDX_W'(k));
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) wstate <= W_IDLE;
    else          wstate <= wstate_nx;
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      have_aw  <= 1'b0;
      have_w   <= 1'b0;
      aw_idx   <= '0;
      aw_ok    <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid   <= 1'b0;
      bresp    <= 2'b00;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (aw_hs) begin
        aw_idx <= S_AXI_AWADDR[ADDR_W-1:ADDR_LSB];
        aw_ok  <= ({1'b0, S_AXI_AWADDR[ADDR_W-1:ADDR_LSB]} < NREGS);
      end
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      case (wstate)
        W_IDLE: begin
          have_aw  <= have_aw_nx;
          have_w   <= have_w_nx;
          aw_ready <= !have_aw_nx;
          w_ready  <= !have_w_nx;
        end
        W_COMMIT: begin
          have_aw  <= 1'b0;
          have_w   <= 1'b0;
          bvalid   <= 1'b1;
          bresp    <= aw_ok ? 2'b00 : 2'b10;
          wr_pulse <= wr_sel;
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid   <= 1'b0;
            bresp    <= 2'b00;
            aw_ready <= 1'b1;
            w_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign S_AXI_AWREADY = aw_ready;
  assign S_AXI_WREADY  = w_ready;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;

  // ---------------- read channel ----------------
  rstate_t           rstate, rstate_nx;
  logic              ar_ready, ar_hs, ar_ok, rvalid;
  logic [IDX_W-1:0]  ar_idx;
  logic [DATA_W-1:0] rd_val, rdata;
  logic [1:0]        rresp;

  always_comb begin
    rstate_nx = rstate;
    ar_hs     = (rstate == R_IDLE) && S_AXI_ARVALID && ar_ready;
    ar_idx    = S_AXI_ARADDR[ADDR_W-1:ADDR_LSB];
    ar_ok     = ({1'b0, ar_idx} < NREGS);
    rd_val    = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (ar_idx == IDX_W'(k)) rd_val = cur[k];
    case (rstate)
      R_IDLE:  if (ar_hs) rstate_nx = R_DATA;
      R_DATA:  if (S_AXI_RREADY) rstate_nx = R_IDLE;
      default: rstate_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) rstate <= R_IDLE;
    else          rstate <= rstate_nx;
  end

  // Capture uses the pre-edge contents, so a same-edge write commit is not visible.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ar_ready <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= 2'b00;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            ar_ready <= 1'b0;
            rvalid   <= 1'b1;
            rdata    <= ar_ok ? rd_val : '0;
            rresp    <= ar_ok ? 2'b00 : 2'b10;
          end else begin
            ar_ready <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid   <= 1'b0;
            ar_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign S_AXI_ARREADY = ar_ready;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RDATA   = rdata;
  assign S_AXI_RRESP   = rresp;

  // ---------------- storage ----------------
`ifdef AXIL_REG_BANK_TMR_EN
  logic [DATA_W-1:0]   tmr_copy [NUM_REGS][3];
  logic [NUM_REGS-1:0] mismatch;
  logic                tmr_err_q;

  always_comb begin
    mismatch = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      cur[k] = (tmr_copy[k][0] & tmr_copy[k][1]) |
               (tmr_copy[k][1] & tmr_copy[k][2]) |
               (tmr_copy[k][0] & tmr_copy[k][2]);
      mismatch[k] = (tmr_copy[k][0] != tmr_copy[k][1]) ||
                    (tmr_copy[k][1] != tmr_copy[k][2]);
    end
  end

  // A committing write overrides the scrub rewrite of the same register.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      tmr_err_q <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++)
        for (int c = 0; c < 3; c++)
          tmr_copy[k][c] <= RESET_VAL;
    end else begin
      tmr_err_q <= |mismatch;
      for (int k = 0; k < NUM_REGS; k++) begin
        if (commit && wr_sel[k]) begin
          for (int c = 0; c < 3; c++)
            tmr_copy[k][c] <= merge_bytes(cur[k], wdata_q, wstrb_q);
        end else if (mismatch[k]) begin
          for (int c = 0; c < 3; c++)
            tmr_copy[k][c] <= cur[k];
        end
      end
    end
  end

  assign tmr_err = tmr_err_q;
`else
  logic [DATA_W-1:0] store [NUM_REGS];

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_REGS; k++)
        store[k] <= RESET_VAL;
    end else begin
      for (int k = 0; k < NUM_REGS; k++)
        if (commit && wr_sel[k])
          store[k] <= merge_bytes(store[k], wdata_q, wstrb_q);
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++)
      cur[k] = store[k];
  end

  assign tmr_err = 1'b0;
`endif

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    assign regs_out[k*DATA_W +: DATA_W] = cur[k];
  end

endmodule

`default_nettype wire

// File: tb/tb_axil_reg_bank.sv
// tb_axil_reg_bank: directed self-checking bench for axil_reg_bank (32-bit, 4 regs, 5-bit address).
`timescale 1ns/1ps
`default_nettype none

module tb_axil_reg_bank;

  localparam int          DATA_W    = 32;
  localparam int          NUM_REGS  = 4;
  localparam int          ADDR_W    = 5;
  localparam logic [31:0] RESET_VAL = 32'h5A5A_0F0F;

  logic         clk = 1'b0;
  logic         arstn = 1'b0;
  logic [4:0]   awaddr = '0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [4:0]   araddr = '0;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [127:0] regs_out;
  logic [3:0]   wr_pulse;
  logic         tmr_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axil_reg_bank #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .RESET_VAL(RESET_VAL)
  ) dut (
    .ACLK(clk), .ARESETN(arstn),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .regs_out(regs_out), .wr_pulse(wr_pulse), .tmr_err(tmr_err)
  );

  // Issue AW and W together; returns #1 after the edge on which both have been accepted.
  task automatic send_aw_w(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    bit aw_done = 0, w_done = 0, a_hs, d_hs;
    int n = 0;
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge clk);
      a_hs = awvalid && awready;
      d_hs = wvalid && wready;
      @(posedge clk); #1;
      if (a_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (d_hs) begin wvalid = 1'b0; w_done = 1; end
      n++;
    end
    if (!(aw_done && w_done)) begin
      checks++; failures++;
      $display("FAIL aw_w_timeout addr=%h aw_done=%0d w_done=%0d", addr, aw_done, w_done);
      awvalid = 1'b0; wvalid = 1'b0;
    end
  endtask

  task automatic wait_b(output logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    @(negedge clk);
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    if (!bvalid) begin
      checks++; failures++;
      $display("FAIL b_timeout bvalid=%b required=1", bvalid);
      resp = 2'bxx;
    end else begin
      resp = bresp;
    end
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    send_aw_w(addr, data, strb);
    wait_b(resp);
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n = 0;
    araddr = addr; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    if (!rvalid) begin
      checks++; failures++;
      $display("FAIL r_timeout addr=%h rvalid=%b required=1", addr, rvalid);
      data = 'x; resp = 2'bxx;
    end else begin
      data = rdata; resp = rresp;
    end
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      failures++;
      $display("FAIL reset_handshake got=%b required=00000", {awready, wready, arready, bvalid, rvalid});
    end
    checks++;
    if ({bresp, rresp, rdata, wr_pulse, tmr_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs bresp=%b rresp=%b rdata=%h pulse=%b tmr_err=%b required all zero",
               bresp, rresp, rdata, wr_pulse, tmr_err);
    end
    for (int k = 0; k < NUM_REGS; k++) begin
      checks++;
      if (regs_out[k*32 +: 32] !== RESET_VAL) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h required=%h", k, regs_out[k*32 +: 32], RESET_VAL);
      end
    end
    arstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      failures++;
      $display("FAIL ready_after_reset got=%b required=111", {awready, wready, arready});
    end
  endtask

  task automatic test_basic_rw();
    logic [1:0]  resp;
    logic [31:0] d;
    for (int k = 0; k < 4; k++) begin
      axi_write(5'(k*4), 32'(k+1), 4'hF, resp);
      checks++;
      if (resp !== 2'b00) begin
        failures++;
        $display("FAIL basic_bresp reg%0d got=%b required=00", k, resp);
      end
    end
    for (int k = 0; k < 4; k++) begin
      axi_read(5'(k*4), d, resp);
      checks++;
      if (d !== 32'(k+1) || resp !== 2'b00) begin
        failures++;
        $display("FAIL basic_read reg%0d got=%h/%b required=%h/00", k, d, resp, 32'(k+1));
      end
    end
  endtask

  task automatic test_strobes();
    logic [1:0]  resp;
    logic [31:0] d;
    axi_write(5'h04, 32'hAABBCCDD, 4'hF, resp);
    axi_write(5'h04, 32'h11223344, 4'b0101, resp);
    axi_read(5'h04, d, resp);
    checks++;
    if (d !== 32'hAA22CC44 || resp !== 2'b00) begin
      failures++;
      $display("FAIL strobe_merge got=%h/%b required=aa22cc44/00", d, resp);
    end
  endtask

  task automatic test_strb_zero();
    logic [1:0] resp;
    send_aw_w(5'h0C, 32'hFFFF_FFFF, 4'h0);
    @(posedge clk); #1;
    checks++;
    if (wr_pulse !== 4'b1000) begin
      failures++;
      $display("FAIL strb0_pulse got=%b required=1000", wr_pulse);
    end
    wait_b(resp);
    checks++;
    if (resp !== 2'b00 || regs_out[3*32 +: 32] !== 32'h4) begin
      failures++;
      $display("FAIL strb0_write resp=%b reg3=%h required 00/00000004", resp, regs_out[3*32 +: 32]);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0]  resp;
    logic [31:0] d;
    axi_write(5'h10, 32'h0000DEAD, 4'hF, resp);
    checks++;
    if (resp !== 2'b10) begin
      failures++;
      $display("FAIL oor_bresp got=%b required=10", resp);
    end
    checks++;
    if (regs_out !== {32'h4, 32'h3, 32'hAA22CC44, 32'h1}) begin
      failures++;
      $display("FAIL oor_regs_changed got=%h required=%h", regs_out, {32'h4, 32'h3, 32'hAA22CC44, 32'h1});
    end
    axi_read(5'h10, d, resp);
    checks++;
    if (d !== 32'h0 || resp !== 2'b10) begin
      failures++;
      $display("FAIL oor_read got=%h/%b required=00000000/10", d, resp);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0]  resp;
    logic [31:0] d;
    int  pulse_cnt = 0;
    bit  ready_bad = 0;
    wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (wready !== 1'b0 || awready !== 1'b1) ready_bad = 1;
    end
    @(posedge clk); #1;
    awaddr = 5'h04; awvalid = 1'b1;
    @(negedge clk);
    if (awready !== 1'b1) ready_bad = 1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    checks++;
    if (ready_bad) begin
      failures++;
      $display("FAIL w_first_ready_sequence ready_bad=%0d required=0", ready_bad);
    end
    ready_bad = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (wr_pulse[1]) pulse_cnt++;
      if (awready || wready) ready_bad = 1;
    end
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      failures++;
      $display("FAIL bvalid_held got=%b/%b required=1/00", bvalid, bresp);
    end
    checks++;
    if (ready_bad) begin
      failures++;
      $display("FAIL ready_during_resp ready_bad=%0d required=0", ready_bad);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    if (wr_pulse[1]) pulse_cnt++;
    checks++;
    if (bvalid !== 1'b0 || {awready, wready} !== 2'b11) begin
      failures++;
      $display("FAIL after_b_handshake bvalid=%b ready=%b required 0/11", bvalid, {awready, wready});
    end
    checks++;
    if (pulse_cnt !== 1) begin
      failures++;
      $display("FAIL wr_pulse_width got=%0d required=1", pulse_cnt);
    end
    axi_read(5'h04, d, resp);
    checks++;
    if (d !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL w_first_value got=%h required=0badf00d", d);
    end
  endtask

  task automatic test_reset_mid_write();
    int  n = 0;
    bit  saw_b = 0;
    send_aw_w(5'h08, 32'h12345678, 4'hF);
    @(negedge clk);
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (bvalid !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_setup bvalid=%b required=1", bvalid);
    end
    arstn = 1'b0;
    @(posedge clk); #1;
    arstn = 1'b1;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_state bvalid=%b awready=%b required 0/0", bvalid, awready);
    end
    checks++;
    if (regs_out !== {4{RESET_VAL}}) begin
      failures++;
      $display("FAIL mid_reset_regs got=%h required=%h", regs_out, {4{RESET_VAL}});
    end
    bready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bvalid) saw_b = 1;
    end
    bready = 1'b0;
    checks++;
    if (saw_b || awready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_no_b saw_b=%0d awready=%b required 0/1", saw_b, awready);
    end
  endtask

`ifdef AXIL_REG_BANK_TMR_EN
  task automatic test_tmr();
    logic [1:0]  resp;
    logic [31:0] d;
    axi_write(5'h08, 32'h3, 4'hF, resp);
    @(negedge clk);
    dut.tmr_copy[2][1][0] = ~dut.tmr_copy[2][1][0];
    #1;
    checks++;
    if (regs_out[2*32 +: 32] !== 32'h3) begin
      failures++;
      $display("FAIL tmr_vote got=%h required=00000003", regs_out[2*32 +: 32]);
    end
    @(posedge clk); #1;
    checks++;
    if (tmr_err !== 1'b1 || dut.tmr_copy[2][1] !== 32'h3) begin
      failures++;
      $display("FAIL tmr_detect tmr_err=%b copy1=%h required 1/00000003", tmr_err, dut.tmr_copy[2][1]);
    end
    @(posedge clk); #1;
    checks++;
    if (tmr_err !== 1'b0) begin
      failures++;
      $display("FAIL tmr_pulse_width tmr_err=%b required=0", tmr_err);
    end
    axi_read(5'h08, d, resp);
    checks++;
    if (d !== 32'h3) begin
      failures++;
      $display("FAIL tmr_read got=%h required=00000003", d);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_rw();
    test_strobes();
    test_strb_zero();
    test_out_of_range();
    test_w_before_aw();
    test_reset_mid_write();
`ifdef AXIL_REG_BANK_TMR_EN
    test_tmr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
